// File: rtl/edf_tx_scheduler.sv
// rtl/edf_tx_scheduler.sv - earliest-deadline transmit scheduler between a priority FIFO and a link
//
// Pops entries from a priority FIFO (head = earliest deadline), stamps them
// against a free-running time base and presents them on a valid/ready link.
//
// Parameters:
//   TICK_DIV  - clock cycles per increment of the time base (1..65535)
//   DROP_LATE - 1: discard deadline-missed entries, 0: transmit them flagged
// Ports:
//   clk         - single clock, rising edge
//   rst         - synchronous active-low reset
//   fifo_empty  - priority FIFO empty flag
//   fifo_re     - FIFO read strobe, one cycle per read
//   fifo_dout   - FIFO head entry: [15:8] absolute deadline, [7:0] payload
//   fifo_valid  - qualifies fifo_dout for one cycle after a read
//   tx_data     - payload presented to the link
//   tx_deadline - deadline of the presented payload
//   tx_late     - presented payload missed its deadline
//   tx_valid    - link output valid
//   tx_ready    - link accept
//   now         - current time base
//   miss        - single-cycle deadline-miss pulse
//   miss_cnt    - saturating miss count
module edf_tx_scheduler #(
  parameter int TICK_DIV  = 10,
  parameter bit DROP_LATE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  output logic        fifo_re,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_valid,
  output logic [7:0]  tx_data,
  output logic [7:0]  tx_deadline,
  output logic        tx_late,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  now,
  output logic        miss,
  output logic [15:0] miss_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  state_t      state;
  logic [15:0] presc;
  logic [7:0]  slack;
  logic        late;

  // Wrap-aware compare: deadline lies in the past when the signed distance
  // from now to the deadline is negative. Equal to now is still on time.
  assign slack = fifo_dout[15:8] - now;
  assign late  = slack[7];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      presc       <= 16'd0;
      now         <= 8'd0;
      fifo_re     <= 1'b0;
      tx_data     <= 8'd0;
      tx_deadline <= 8'd0;
      tx_late     <= 1'b0;
      tx_valid    <= 1'b0;
      miss        <= 1'b0;
      miss_cnt    <= 16'd0;
    end else begin
      if (presc == PRESC_MAX) begin
        presc <= 16'd0;
        now   <= now + 8'd1;
      end else begin
        presc <= presc + 16'd1;
      end

      miss <= 1'b0;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state   <= REQ;
            fifo_re <= 1'b1;
          end
        end
        REQ: begin
          state   <= WAIT;
          fifo_re <= 1'b0;
        end
        WAIT: begin
          if (fifo_valid) begin
            tx_deadline <= fifo_dout[15:8];
            tx_data     <= fifo_dout[7:0];
            miss        <= late;
            if (late && (miss_cnt != 16'hFFFF))
              miss_cnt <= miss_cnt + 16'd1;
            if (late && DROP_LATE) begin
              state <= IDLE;
            end else begin
              state    <= HOLD;
              tx_valid <= 1'b1;
              tx_late  <= late;
            end
          end
        end
        HOLD: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            // Chain straight into the next read to keep 3-cycle throughput.
            if (!fifo_empty) begin
              state   <= REQ;
              fifo_re <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edf_tx_scheduler.sv
// tb/tb_edf_tx_scheduler.sv - directed self-checking bench for edf_tx_scheduler
module tb_edf_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_ready = 1'b0;

  logic        fifo_empty = 1'b1;
  logic        fifo_valid = 1'b0;
  logic [15:0] fifo_dout = 16'd0;
  logic        fifo_re;
  logic [7:0]  tx_data, tx_deadline, now;
  logic        tx_late, tx_valid, miss;
  logic [15:0] miss_cnt;

  logic        fifo_empty1 = 1'b1;
  logic        fifo_valid1 = 1'b0;
  logic [15:0] fifo_dout1 = 16'd0;
  logic        fifo_re1;
  logic [7:0]  tx_data1, tx_deadline1, now1;
  logic        tx_late1, tx_valid1, miss1;
  logic [15:0] miss_cnt1;

  int ncmp = 0;
  int nerr = 0;
  logic re_seen;

  always #5 clk = ~clk;

  edf_tx_scheduler #(.TICK_DIV(10), .DROP_LATE(1'b0)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
    .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .tx_data(tx_data),
    .tx_deadline(tx_deadline), .tx_late(tx_late), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .now(now), .miss(miss), .miss_cnt(miss_cnt)
  );

  edf_tx_scheduler #(.TICK_DIV(10), .DROP_LATE(1'b1)) dut_drop (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_re(fifo_re1),
    .fifo_dout(fifo_dout1), .fifo_valid(fifo_valid1), .tx_data(tx_data1),
    .tx_deadline(tx_deadline1), .tx_late(tx_late1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready), .now(now1), .miss(miss1), .miss_cnt(miss_cnt1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fifo_empty = 1'b1; fifo_valid = 1'b0;
    fifo_empty1 = 1'b1; fifo_valid1 = 1'b0;
    tx_ready = 1'b0;
    ticks(2);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_fifo_re", 16'(fifo_re), 16'd0);
    check("rst_tx_valid", 16'(tx_valid), 16'd0);
    check("rst_tx_late", 16'(tx_late), 16'd0);
    check("rst_tx_data", 16'(tx_data), 16'd0);
    check("rst_tx_deadline", 16'(tx_deadline), 16'd0);
    check("rst_now", 16'(now), 16'd0);
    check("rst_miss", 16'(miss), 16'd0);
    check("rst_miss_cnt", miss_cnt, 16'd0);
    check("rst_drop_tx_valid", 16'(tx_valid1), 16'd0);

    // Empty FIFO for 100 cycles: no reads, time base at 10
    do_reset();
    re_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      re_seen = re_seen | fifo_re;
    end
    check("idle_no_re", 16'(re_seen), 16'd0);
    check("idle_tx_valid", 16'(tx_valid), 16'd0);
    check("idle_now10", 16'(now), 16'd10);

    // Single entry 3C2A at now=5, latency n+1/n+2/n+3
    do_reset();
    ticks(50);
    check("b_now5", 16'(now), 16'd5);
    fifo_empty = 1'b0; tx_ready = 1'b1;      // cycle n
    tick();                                  // n+1
    check("b_re_n1", 16'(fifo_re), 16'd1);
    check("b_txv_n1", 16'(tx_valid), 16'd0);
    fifo_empty = 1'b1;
    tick();                                  // n+2
    check("b_re_n2", 16'(fifo_re), 16'd0);
    check("b_txv_n2", 16'(tx_valid), 16'd0);
    fifo_valid = 1'b1; fifo_dout = 16'h3C2A;
    tick();                                  // n+3
    fifo_valid = 1'b0;
    check("b_txv_n3", 16'(tx_valid), 16'd1);
    check("b_data", 16'(tx_data), 16'h2A);
    check("b_deadline", 16'(tx_deadline), 16'h3C);
    check("b_late", 16'(tx_late), 16'd0);
    check("b_miss", 16'(miss), 16'd0);
    tick();
    check("b_txv_one_cycle", 16'(tx_valid), 16'd0);
    check("b_re_after", 16'(fifo_re), 16'd0);

    // Back-pressure: hold 20 cycles, then handshake chains into the next read
    tx_ready = 1'b0; fifo_empty = 1'b0;
    tick();
    check("c_re", 16'(fifo_re), 16'd1);
    tick();
    fifo_valid = 1'b1; fifo_dout = 16'h4077;
    // spurious ready outside HOLD must do nothing
    tx_ready = 1'b1;
    tick();
    fifo_valid = 1'b0; fifo_dout = 16'h0000;
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("c_hold_valid", 16'(tx_valid), 16'd1);
      check("c_hold_data", 16'(tx_data), 16'h77);
      check("c_hold_deadline", 16'(tx_deadline), 16'h40);
      check("c_hold_no_re", 16'(fifo_re), 16'd0);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    check("c_hs_txv_fall", 16'(tx_valid), 16'd0);
    check("c_hs_next_re", 16'(fifo_re), 16'd1);
    fifo_empty = 1'b1;
    tick();
    check("c_wait_re", 16'(fifo_re), 16'd0);
    fifo_valid = 1'b1; fifo_dout = 16'h5066;
    tick();
    fifo_valid = 1'b0;
    check("c_second_valid", 16'(tx_valid), 16'd1);
    check("c_second_data", 16'(tx_data), 16'h66);
    tick();
    check("c_second_done", 16'(tx_valid), 16'd0);

    // Wrapped future: now=200, deadline 05 is not late
    do_reset();
    ticks(2000);
    check("d_now200", 16'(now), 16'd200);
    fifo_empty = 1'b0; tx_ready = 1'b1;
    tick();
    fifo_empty = 1'b1;
    tick();
    fifo_valid = 1'b1; fifo_dout = 16'h05A5;
    tick();
    fifo_valid = 1'b0;
    check("d_wrap_valid", 16'(tx_valid), 16'd1);
    check("d_wrap_late", 16'(tx_late), 16'd0);
    check("d_wrap_miss", 16'(miss), 16'd0);
    check("d_wrap_cnt", miss_cnt, 16'd0);
    tick();

    // Past deadline: now=10, deadline 04 is late
    do_reset();
    ticks(100);
    check("d2_now10", 16'(now), 16'd10);
    fifo_empty = 1'b0; tx_ready = 1'b1;
    tick();
    fifo_empty = 1'b1;
    tick();
    fifo_valid = 1'b1; fifo_dout = 16'h0499;
    tick();
    fifo_valid = 1'b0;
    check("d2_valid", 16'(tx_valid), 16'd1);
    check("d2_late", 16'(tx_late), 16'd1);
    check("d2_miss", 16'(miss), 16'd1);
    check("d2_cnt", miss_cnt, 16'd1);
    check("d2_data", 16'(tx_data), 16'h99);
    tick();
    check("d2_miss_pulse", 16'(miss), 16'd0);
    check("d2_cnt_hold", miss_cnt, 16'd1);
    check("d2_done", 16'(tx_valid), 16'd0);

    // DROP_LATE=1: late entry 0411 at now=50 is discarded, next entry read
    do_reset();
    ticks(500);
    check("e_now50", 16'(now1), 16'd50);
    fifo_empty1 = 1'b0; tx_ready = 1'b1;
    tick();
    check("e_re", 16'(fifo_re1), 16'd1);
    tick();
    fifo_valid1 = 1'b1; fifo_dout1 = 16'h0411;
    tick();
    fifo_valid1 = 1'b0;
    check("e_miss", 16'(miss1), 16'd1);
    check("e_txv_low", 16'(tx_valid1), 16'd0);
    check("e_cnt", miss_cnt1, 16'd1);
    check("e_idle_no_re", 16'(fifo_re1), 16'd0);
    tick();
    check("e_next_re", 16'(fifo_re1), 16'd1);
    check("e_txv_still_low", 16'(tx_valid1), 16'd0);
    check("e_miss_pulse", 16'(miss1), 16'd0);
    fifo_empty1 = 1'b1;
    tick();
    fifo_valid1 = 1'b1; fifo_dout1 = 16'h6022;
    tick();
    fifo_valid1 = 1'b0;
    check("e_next_valid", 16'(tx_valid1), 16'd1);
    check("e_next_data", 16'(tx_data1), 16'h22);
    check("e_next_late", 16'(tx_late1), 16'd0);
    tick();

    // Reset in WAIT: late fifo_valid is ignored
    do_reset();
    fifo_empty = 1'b0;
    tick();
    check("f_re", 16'(fifo_re), 16'd1);
    tick();                                  // WAIT
    rst = 1'b0; fifo_empty = 1'b1;
    tick();
    check("f_rst_re", 16'(fifo_re), 16'd0);
    rst = 1'b1;
    fifo_valid = 1'b1; fifo_dout = 16'h0133;
    tick();
    fifo_valid = 1'b0;
    tick();
    check("f_txv", 16'(tx_valid), 16'd0);
    check("f_data", 16'(tx_data), 16'd0);
    check("f_deadline", 16'(tx_deadline), 16'd0);
    check("f_late", 16'(tx_late), 16'd0);
    check("f_miss", 16'(miss), 16'd0);
    check("f_cnt", miss_cnt, 16'd0);
    check("f_re_after", 16'(fifo_re), 16'd0);
    check("f_now", 16'(now), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/edf_tx_scheduler.md
EDF_TX_SCHEDULER -- requirements
Module: edf_tx_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 10, meaning clock cycles per increment of the deadline time base (range 1..65535).
REQ-002 The block SHALL have parameter DROP_LATE, default 0, meaning: 1 discards deadline-missed packets, 0 transmits them flagged.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-low reset (rst=0 resets on the next clk edge).
REQ-005 The block SHALL have port fifo_empty, input, 1, the priority FIFO empty flag.
REQ-006 The block SHALL have port fifo_re, output, 1, the priority FIFO read strobe.
REQ-007 The block SHALL have port fifo_dout, input, 16, the FIFO head entry: [15:8] absolute deadline, [7:0] payload.
REQ-008 The block SHALL have port fifo_valid, input, 1, which qualifies fifo_dout for one cycle.
REQ-009 The block SHALL have port tx_data, output, 8, the payload presented to the link.
REQ-010 The block SHALL have port tx_deadline, output, 8, the deadline of the presented payload.
REQ-011 The block SHALL have port tx_late, output, 1, set when the presented packet missed its deadline.
REQ-012 The block SHALL have port tx_valid, output, 1, meaning the link output is valid.
REQ-013 The block SHALL have port tx_ready, input, 1, the link accept signal.
REQ-014 The block SHALL have port now, output, 8, the current time base.
REQ-015 The block SHALL have port miss, output, 1, a single-cycle deadline-miss pulse.
REQ-016 The block SHALL have port miss_cnt, output, 16, the saturating count of misses.

Function
REQ-017 The time base SHALL use a prescaler that counts 0..TICK_DIV-1; now SHALL increment by 1 mod 256 in the cycle the prescaler wraps.
REQ-018 The FSM SHALL have four states: IDLE, REQ, WAIT and HOLD.
REQ-019 IDLE SHALL go to REQ when fifo_empty=0 is sampled; otherwise it SHALL remain in IDLE.
REQ-020 fifo_re SHALL be registered, SHALL be 1 exactly during the single cycle in REQ, and SHALL otherwise be 0; at most one read SHALL be outstanding.
REQ-021 REQ SHALL go to WAIT unconditionally.
REQ-022 WAIT SHALL remain in WAIT until fifo_valid=1 is sampled; fifo_valid SHALL be ignored in all states other than WAIT.
REQ-023 On fifo_valid=1 in WAIT, the block SHALL capture fifo_dout into tx_deadline/tx_data and evaluate late = bit 7 of (fifo_dout[15:8] - now) mod 256, a wrap-aware "deadline before now" test; deadline equal to now is not late.
REQ-024 After a capture, if late=1 and DROP_LATE=1, the FSM SHALL go to IDLE with tx_valid held at 0; otherwise it SHALL go to HOLD with tx_valid=1 in the next cycle and tx_late=late.
REQ-025 miss SHALL pulse high for one cycle, the cycle after capture, whenever late=1, regardless of DROP_LATE.
REQ-026 miss_cnt SHALL increment with each miss pulse and SHALL saturate at 16'hFFFF.
REQ-027 In HOLD, tx_data, tx_deadline, tx_late and tx_valid SHALL be held stable until tx_valid and tx_ready are both 1 on the same edge.
REQ-028 On that handshake, the FSM SHALL go to REQ if fifo_empty=0 in that cycle, else to IDLE, and tx_valid SHALL fall on the same edge.
REQ-029 Latency SHALL be: fifo_empty falls at cycle n, fifo_re=1 at n+1, FIFO valid at n+2, tx_valid=1 at n+3.
REQ-030 Back-to-back throughput SHALL be one packet per 3 cycles when tx_ready=1 is held.
REQ-031 tx_ready=1 outside HOLD SHALL have no effect.

Reset
REQ-032 When rst=0 on a clk edge, the block SHALL set state=IDLE, fifo_re=0, tx_valid=0, tx_late=0, tx_data=0, tx_deadline=0, now=0, prescaler=0, miss=0 and miss_cnt=0.
REQ-033 Reset asserted mid-operation (REQ, WAIT or HOLD) SHALL abandon any in-flight or held packet without a handshake; a fifo_valid arriving after reset SHALL be ignored.
REQ-034 While rst=0, fifo_re SHALL remain 0.

Verification
REQ-035 The bench SHALL check: reset then fifo_empty=1 for 100 cycles -> fifo_re never 1, tx_valid=0, now=10 with TICK_DIV=10.
REQ-036 The bench SHALL check: a single entry 16'h3C2A with now=5 and tx_ready=1 -> tx_valid high 1 cycle with tx_data=8'h2A, tx_deadline=8'h3C and tx_late=0, at the cycle timing of REQ-029.
REQ-037 The bench SHALL check: tx_ready=0 for 20 cycles while holding -> outputs stable and no fifo_re; then tx_ready=1 -> handshake, and the next fifo_re follows on the next edge if fifo_empty=0.
REQ-038 The bench SHALL check: now=200 and entry deadline 8'h05 -> not late (wrapped future); now=10 and deadline 8'h04 -> miss pulse, miss_cnt=1, tx_late=1.
REQ-039 The bench SHALL check: DROP_LATE=1 with late entry 16'h0411 at now=50 -> miss=1, tx_valid stays 0, FSM back to IDLE and reads the next entry.
REQ-040 The bench SHALL check: rst=0 asserted in WAIT, then fifo_valid=1 -> no capture, tx_valid=0 and all outputs at their REQ-032 reset values.
